// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus between the cpu_6502 core and its memory responder, plus the
// PPU register and cartridge fan-out driven by the responder.
interface cpu_bus_responder_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_wr;
    logic        cpu_rd;
    logic        cpu_halt;
    logic [2:0]  ppu_reg;
    logic [7:0]  ppu_wdata;
    logic        ppu_wr;
    logic        ppu_rd;
    logic [7:0]  ppu_rdata;
    logic [15:0] cart_addr;
    logic [7:0]  cart_wdata;
    logic        cart_wr;
    logic        cart_rd;
    logic [7:0]  cart_rdata;
    logic        dma_busy;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wr, cpu_rd, ppu_rdata, cart_rdata,
        output cpu_rdata, cpu_halt, ppu_reg, ppu_wdata, ppu_wr, ppu_rd,
               cart_addr, cart_wdata, cart_wr, cart_rd, dma_busy
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wr, cpu_rd, ppu_rdata, cart_rdata,
        input  cpu_rdata, cpu_halt, ppu_reg, ppu_wdata, ppu_wr, ppu_rd,
               cart_addr, cart_wdata, cart_wr, cart_rd, dma_busy
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// NES CPU memory map responder: mirrored 2KB RAM, PPU register window,
// cartridge pass-through and the $4014 OAM DMA engine that halts the CPU.
module cpu_bus_responder #(
    parameter int unsigned RAM_AW   = 11,
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [2:0]  OAM_DATA = 3'd4
) (
    input logic clk,
    input logic rst,
    cpu_bus_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} dma_state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_PPU, SRC_CART} rd_src_t;

    dma_state_t state;
    rd_src_t    rd_src;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] ram_q;
    logic [7:0] rdata_hold;
    logic [7:0] rdata_mux;
    logic [7:0] ram [0:(1 << RAM_AW) - 1];

    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic        m_wr;
    logic        m_rd;
    logic        is_ram;
    logic        is_ppu;
    logic        is_io;
    logic        is_cart;
    logic        dma_wr_phase;

    // The DMA engine takes the bus for its whole run; a simultaneous write
    // suppresses the CPU read.
    always_comb begin
        m_addr  = bus.cpu_addr;
        m_wdata = bus.cpu_wdata;
        m_wr    = 1'b0;
        m_rd    = 1'b0;
        unique case (state)
            IDLE: begin
                m_wr = bus.cpu_wr;
                m_rd = bus.cpu_rd & ~bus.cpu_wr;
            end
            RD: begin
                m_addr = {page, idx};
                m_rd   = 1'b1;
            end
            default: begin
                m_addr = {page, idx};
            end
        endcase
    end

    always_comb begin
        is_ram  = (m_addr[15:13] == 3'b000);
        is_ppu  = (m_addr[15:13] == 3'b001);
        is_io   = (m_addr[15:5] == 11'h200);
        is_cart = ~is_ram & ~is_ppu & ~is_io;
        dma_wr_phase = (state == WR);
    end

    always_comb begin
        unique case (rd_src)
            SRC_RAM:  rdata_mux = ram_q;
            SRC_PPU:  rdata_mux = bus.ppu_rdata;
            SRC_CART: rdata_mux = bus.cart_rdata;
            default:  rdata_mux = rdata_hold;
        endcase
    end

    assign bus.cpu_rdata = rdata_mux;

    always_comb begin
        bus.ppu_rd     = m_rd & is_ppu;
        bus.ppu_wr     = (m_wr & is_ppu) | dma_wr_phase;
        bus.ppu_reg    = '0;
        bus.ppu_wdata  = '0;
        if (dma_wr_phase) begin
            bus.ppu_reg   = OAM_DATA;
            bus.ppu_wdata = rdata_mux;
        end else if (is_ppu & (m_rd | m_wr)) begin
            bus.ppu_reg = m_addr[2:0];
            if (m_wr) bus.ppu_wdata = m_wdata;
        end
        bus.cart_rd    = m_rd & is_cart;
        bus.cart_wr    = m_wr & is_cart;
        bus.cart_addr  = (is_cart & (m_rd | m_wr)) ? m_addr : '0;
        bus.cart_wdata = (is_cart & m_wr) ? m_wdata : '0;
    end

    // RAM array and its read register are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (m_wr && is_ram) ram[m_addr[RAM_AW-1:0]] <= m_wdata;
        if (m_rd && is_ram) ram_q <= ram[m_addr[RAM_AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rd_src       <= SRC_NONE;
            page         <= '0;
            idx          <= '0;
            rdata_hold   <= '0;
            bus.dma_busy <= 1'b0;
            bus.cpu_halt <= 1'b0;
        end else begin
            rdata_hold <= rdata_mux;
            if (!m_rd)        rd_src <= SRC_NONE;
            else if (is_ram)  rd_src <= SRC_RAM;
            else if (is_ppu)  rd_src <= SRC_PPU;
            else if (is_cart) rd_src <= SRC_CART;
            else              rd_src <= SRC_NONE;

            unique case (state)
                IDLE: begin
                    if (bus.cpu_wr && bus.cpu_addr == DMA_REG) begin
                        page         <= bus.cpu_wdata;
                        idx          <= '0;
                        state        <= ALIGN;
                        bus.dma_busy <= 1'b1;
                        bus.cpu_halt <= 1'b1;
                    end
                end
                ALIGN: state <= RD;
                RD:    state <= WR;
                WR: begin
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF) begin
                        state        <= IDLE;
                        bus.dma_busy <= 1'b0;
                        bus.cpu_halt <= 1'b0;
                    end else begin
                        state <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: RAM mirroring, PPU/cart decode,
// OAM DMA length and data order, reset abort and open-bus behaviour.
module tb_cpu_bus_responder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    cpu_bus_responder_if bus();

    cpu_bus_responder #(
        .RAM_AW   (11),
        .DMA_REG  (16'h4014),
        .OAM_DATA (3'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_wr    = 1'b1;
        step();
        bus.cpu_wr    = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a);
        bus.cpu_addr = a;
        bus.cpu_rd   = 1'b1;
        step();
        bus.cpu_rd   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (bus.cpu_rdata !== 8'h00) begin
            bad++; $display("FAIL reset_rdata got=%h exp=00", bus.cpu_rdata);
        end
        total++;
        if ({bus.cpu_halt, bus.dma_busy} !== 2'b00) begin
            bad++; $display("FAIL reset_halt_busy got=%b exp=00", {bus.cpu_halt, bus.dma_busy});
        end
        total++;
        if ({bus.ppu_wr, bus.ppu_rd, bus.cart_wr, bus.cart_rd} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b exp=0000",
                            {bus.ppu_wr, bus.ppu_rd, bus.cart_wr, bus.cart_rd});
        end
        total++;
        if ({bus.ppu_reg, bus.ppu_wdata, bus.cart_addr, bus.cart_wdata} !== 35'd0) begin
            bad++; $display("FAIL reset_addr_data got=%h exp=0",
                            {bus.ppu_reg, bus.ppu_wdata, bus.cart_addr, bus.cart_wdata});
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_ram_mirror();
        logic [15:0] mirrors [3];
        mirrors[0] = 16'h0803;
        mirrors[1] = 16'h1003;
        mirrors[2] = 16'h1803;
        do_write(16'h0003, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            do_read(mirrors[i]);
            total++;
            if (bus.cpu_rdata !== 8'h5A) begin
                bad++; $display("FAIL ram_mirror addr=%h got=%h exp=5a", mirrors[i], bus.cpu_rdata);
            end
        end
        do_write(16'h07FF, 8'hA5);
        do_read(16'h1FFF);
        total++;
        if (bus.cpu_rdata !== 8'hA5) begin
            bad++; $display("FAIL ram_top_mirror got=%h exp=a5", bus.cpu_rdata);
        end
    endtask

    task automatic test_ppu();
        bus.cpu_addr  = 16'h3FFE;
        bus.cpu_rd    = 1'b1;
        bus.ppu_rdata = 8'hC3;
        #1;
        total++;
        if ({bus.ppu_rd, bus.ppu_reg, bus.cart_rd} !== {1'b1, 3'd6, 1'b0}) begin
            bad++; $display("FAIL ppu_read_strobe got rd=%b reg=%0d cart_rd=%b exp rd=1 reg=6 cart_rd=0",
                            bus.ppu_rd, bus.ppu_reg, bus.cart_rd);
        end
        step();
        bus.cpu_rd = 1'b0;
        #1;
        total++;
        if (bus.cpu_rdata !== 8'hC3) begin
            bad++; $display("FAIL ppu_read_data got=%h exp=c3", bus.cpu_rdata);
        end
        bus.cpu_addr  = 16'h2001;
        bus.cpu_wdata = 8'h1E;
        bus.cpu_wr    = 1'b1;
        #1;
        total++;
        if ({bus.ppu_wr, bus.ppu_reg, bus.ppu_wdata} !== {1'b1, 3'd1, 8'h1E}) begin
            bad++; $display("FAIL ppu_write got wr=%b reg=%0d data=%h exp wr=1 reg=1 data=1e",
                            bus.ppu_wr, bus.ppu_reg, bus.ppu_wdata);
        end
        step();
        bus.cpu_wr = 1'b0;
    endtask

    task automatic test_cart();
        do_write(16'h0000, 8'h11);
        bus.cpu_addr  = 16'h8000;
        bus.cpu_wdata = 8'h77;
        bus.cpu_wr    = 1'b1;
        #1;
        total++;
        if ({bus.cart_wr, bus.cart_addr, bus.cart_wdata, bus.ppu_wr} !== {1'b1, 16'h8000, 8'h77, 1'b0}) begin
            bad++; $display("FAIL cart_write got wr=%b addr=%h data=%h ppu_wr=%b exp 1/8000/77/0",
                            bus.cart_wr, bus.cart_addr, bus.cart_wdata, bus.ppu_wr);
        end
        step();
        bus.cpu_wr = 1'b0;
        do_read(16'h0000);
        total++;
        if (bus.cpu_rdata !== 8'h11) begin
            bad++; $display("FAIL cart_ram_untouched got=%h exp=11", bus.cpu_rdata);
        end
        bus.cpu_addr   = 16'hC123;
        bus.cpu_rd     = 1'b1;
        bus.cart_rdata = 8'h9D;
        #1;
        total++;
        if ({bus.cart_rd, bus.cart_addr} !== {1'b1, 16'hC123}) begin
            bad++; $display("FAIL cart_read_strobe got rd=%b addr=%h exp 1/c123", bus.cart_rd, bus.cart_addr);
        end
        step();
        bus.cpu_rd = 1'b0;
        #1;
        total++;
        if (bus.cpu_rdata !== 8'h9D) begin
            bad++; $display("FAIL cart_read_data got=%h exp=9d", bus.cpu_rdata);
        end
    endtask

    task automatic test_dma();
        int halt_cnt;
        int wr_cnt;
        logic [7:0] exp_d;
        for (int i = 0; i < 256; i++) begin
            exp_d = 8'(i) ^ 8'hFF;
            do_write(16'h0200 + 16'(i), exp_d);
        end
        do_write(16'h4014, 8'h02);
        total++;
        if ({bus.cpu_halt, bus.dma_busy} !== 2'b11) begin
            bad++; $display("FAIL dma_start got halt/busy=%b exp=11", {bus.cpu_halt, bus.dma_busy});
        end
        // CPU write attempted throughout the DMA must be ignored
        bus.cpu_addr  = 16'h0200;
        bus.cpu_wdata = 8'h00;
        bus.cpu_wr    = 1'b1;
        halt_cnt = 1;
        wr_cnt   = 0;
        for (int c = 0; c < 600; c++) begin
            if (bus.ppu_wr === 1'b1) begin
                exp_d = 8'hFF - 8'(wr_cnt);
                total++;
                if (bus.ppu_reg !== 3'd4 || bus.ppu_wdata !== exp_d) begin
                    bad++; $display("FAIL dma_word n=%0d got reg=%0d data=%h exp reg=4 data=%h",
                                    wr_cnt, bus.ppu_reg, bus.ppu_wdata, exp_d);
                end
                wr_cnt++;
            end
            step();
            if (bus.cpu_halt !== 1'b1) begin
                bus.cpu_wr = 1'b0;
                break;
            end
            halt_cnt++;
        end
        bus.cpu_wr = 1'b0;
        total++;
        if (halt_cnt != 513) begin
            bad++; $display("FAIL dma_halt_len got=%0d exp=513", halt_cnt);
        end
        total++;
        if (wr_cnt != 256) begin
            bad++; $display("FAIL dma_wr_count got=%0d exp=256", wr_cnt);
        end
        total++;
        if (bus.dma_busy !== 1'b0) begin
            bad++; $display("FAIL dma_busy_end got=%b exp=0", bus.dma_busy);
        end
        do_read(16'h0200);
        total++;
        if (bus.cpu_rdata !== 8'hFF) begin
            bad++; $display("FAIL dma_cpu_wr_ignored got=%h exp=ff", bus.cpu_rdata);
        end
    endtask

    task automatic test_dma_reset();
        int wr_seen;
        do_write(16'h4014, 8'h02);
        for (int c = 1; c < 100; c++) step();
        rst = 1'b1;
        #1;
        total++;
        if ({bus.cpu_halt, bus.dma_busy, bus.ppu_wr} !== 3'b000) begin
            bad++; $display("FAIL dma_reset_abort got halt/busy/ppu_wr=%b exp=000",
                            {bus.cpu_halt, bus.dma_busy, bus.ppu_wr});
        end
        step();
        rst = 1'b0;
        wr_seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.ppu_wr !== 1'b0 || bus.cpu_halt !== 1'b0) wr_seen++;
        end
        total++;
        if (wr_seen != 0) begin
            bad++; $display("FAIL dma_not_resumed active_cycles=%0d exp=0", wr_seen);
        end
        do_read(16'h0201);
        total++;
        if (bus.cpu_rdata !== 8'hFE) begin
            bad++; $display("FAIL post_reset_read got=%h exp=fe", bus.cpu_rdata);
        end
    endtask

    task automatic test_open_bus();
        do_read(16'h0803);
        do_read(16'h4015);
        total++;
        if (bus.cpu_rdata !== 8'h5A) begin
            bad++; $display("FAIL open_bus_read got=%h exp=5a", bus.cpu_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (bus.cpu_rdata !== 8'h5A) begin
                bad++; $display("FAIL open_bus_idle cycle=%0d got=%h exp=5a", c, bus.cpu_rdata);
            end
        end
        do_write(16'h0010, 8'h33);
        bus.cpu_addr  = 16'h0010;
        bus.cpu_wdata = 8'hC8;
        bus.cpu_wr    = 1'b1;
        bus.cpu_rd    = 1'b1;
        step();
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b0;
        #1;
        total++;
        if (bus.cpu_rdata !== 8'h5A) begin
            bad++; $display("FAIL rdwr_read_ignored got=%h exp=5a", bus.cpu_rdata);
        end
        do_read(16'h0010);
        total++;
        if (bus.cpu_rdata !== 8'hC8) begin
            bad++; $display("FAIL rdwr_write_wins got=%h exp=c8", bus.cpu_rdata);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.cpu_wr     = 1'b0;
        bus.cpu_rd     = 1'b0;
        bus.ppu_rdata  = '0;
        bus.cart_rdata = '0;
        test_reset();
        test_ram_mirror();
        test_ppu();
        test_cart();
        test_dma();
        test_dma_reset();
        test_open_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
